// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared constants for the pipeline control slice.
// Holds the machine word size, the opcode map, the hazard FSM state
// encoding and the pipeline-register indices used by the stall/flush
// vectors inside pipeline_hazard_controller.
package pipeline_hazard_controller_pkg;

  localparam int WORD_SIZE = 16;

  // Opcode map shared by the decoder and the controller slice.
  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_LWD  = 4'h7;
  localparam logic [3:0] OP_SWD  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h0 + 4'h1;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // Register-file address (four architectural registers).
  typedef logic [1:0] reg_addr_t;

  // Hazard controller FSM.
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_HALTED    = 2'd2
  } hazard_state_t;

  // Pipeline-register indices into the stall/flush vectors.
  localparam int STAGE_IF_ID  = 0;
  localparam int STAGE_ID_EX  = 1;
  localparam int STAGE_EX_MEM = 2;
  localparam int STAGE_MEM_WB = 3;
  localparam int NUM_STAGES   = 4;

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// load_use_detector: purely combinational load-use hazard detection.
// Flags when the load in EX writes a register that the instruction in
// ID actually reads (rs and/or rt, qualified by their use flags).
// Ports:
//   d_readM_EX        in  EX-stage instruction is a load
//   write_reg_addr_EX in  load destination register
//   rs_ID, rt_ID      in  ID source register addresses
//   use_rs_ID/rt_ID   in  source operand is really read
//   load_use          out hazard present this cycle
module load_use_detector
  import pipeline_hazard_controller_pkg::*;
(
  input  logic      d_readM_EX,
  input  reg_addr_t write_reg_addr_EX,
  input  reg_addr_t rs_ID,
  input  reg_addr_t rt_ID,
  input  logic      use_rs_ID,
  input  logic      use_rt_ID,
  output logic      load_use
);

  assign load_use = d_readM_EX &
                    ((use_rs_ID & (rs_ID == write_reg_addr_EX)) |
                     (use_rt_ID & (rt_ID == write_reg_addr_EX)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush control for a 4-register
// (IF/ID, ID/EX, EX/MEM, MEM/WB) pipeline.
// The only sequential control is the RUN / DMEM_WAIT / HALTED state
// register; stage controls are combinational from state and inputs.
// Event priority, highest first: HALTED, data-memory stall, EX
// mispredict, load-use, ID jump, instruction fetch not ready.
// Ports:
//   clk, reset_n            rising-edge clock, synchronous active-low reset
//   i_ready, d_ready        fetch data valid / MEM access completes
//   d_readM_MEM/d_writeM_MEM MEM-stage access request
//   d_readM_EX, write_reg_addr_EX, rs_ID, rt_ID, use_rs_ID, use_rt_ID
//                           load-use hazard inputs
//   isJump_ID, mispredict_EX, is_halted_WB  control-flow events
//   pc_write, stall_*, flush_*, halted      stage controls
//   stall_cycles, flush_count               performance counters
// Optional feature: define HAZARD_PERF_COUNTER_EN to build the saturating
// performance counters; otherwise both counter outputs are tied to zero.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_ready,
  input  logic             d_ready,
  input  logic             d_readM_MEM,
  input  logic             d_writeM_MEM,
  input  logic             d_readM_EX,
  input  logic [1:0]       write_reg_addr_EX,
  input  logic [1:0]       rs_ID,
  input  logic [1:0]       rt_ID,
  input  logic             use_rs_ID,
  input  logic             use_rt_ID,
  input  logic             isJump_ID,
  input  logic             mispredict_EX,
  input  logic             is_halted_WB,
  output logic             pc_write,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_MEM,
  output logic             stall_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             flush_MEM_WB,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  hazard_state_t         state;
  logic                  dmem_stall;
  logic                  load_use;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] flush;

  assign dmem_stall = (d_readM_MEM | d_writeM_MEM) & ~d_ready;

  load_use_detector u_load_use_detector (
    .d_readM_EX        (d_readM_EX),
    .write_reg_addr_EX (write_reg_addr_EX),
    .rs_ID             (rs_ID),
    .rt_ID             (rt_ID),
    .use_rs_ID         (use_rs_ID),
    .use_rt_ID         (use_rt_ID),
    .load_use          (load_use)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else if (is_halted_WB) begin
      state <= ST_HALTED;
    end else begin
      case (state)
        ST_RUN:       if (dmem_stall) state <= ST_DMEM_WAIT;
        ST_DMEM_WAIT: if (d_ready)    state <= ST_RUN;
        ST_HALTED:    state <= ST_HALTED;
        default:      state <= ST_RUN;
      endcase
    end
  end

  // NOTE: every output gets a default before the priority chain so no
  // path through the block can infer a latch.
  always_comb begin
    pc_write = 1'b1;
    stall    = '0;
    flush    = '0;
    halted   = 1'b0;
    if (!reset_n) begin
      // Drain the pipe while reset is held.
      pc_write = 1'b0;
      flush    = '1;
    end else if (state == ST_HALTED) begin
      pc_write = 1'b0;
      stall    = '1;
      halted   = 1'b1;
    end else if (dmem_stall) begin
      // Freeze everything up to MEM; MEM/WB gets a bubble.
      pc_write            = 1'b0;
      stall[STAGE_IF_ID]  = 1'b1;
      stall[STAGE_ID_EX]  = 1'b1;
      stall[STAGE_EX_MEM] = 1'b1;
      flush[STAGE_MEM_WB] = 1'b1;
    end else if (mispredict_EX) begin
      // Redirect PC; the two younger instructions are wrong-path.
      flush[STAGE_IF_ID] = 1'b1;
      flush[STAGE_ID_EX] = 1'b1;
    end else if (load_use) begin
      // Hold ID one cycle and inject one bubble into EX.
      pc_write           = 1'b0;
      stall[STAGE_IF_ID] = 1'b1;
      flush[STAGE_ID_EX] = 1'b1;
    end else begin
      // Jump and fetch-not-ready both squash IF/ID; fetch-not-ready
      // additionally holds the PC.
      if (isJump_ID) begin
        flush[STAGE_IF_ID] = 1'b1;
      end
      if (!i_ready) begin
        pc_write           = 1'b0;
        flush[STAGE_IF_ID] = 1'b1;
      end
    end
  end

  assign stall_IF_ID  = stall[STAGE_IF_ID];
  assign stall_ID_EX  = stall[STAGE_ID_EX];
  assign stall_EX_MEM = stall[STAGE_EX_MEM];
  assign stall_MEM_WB = stall[STAGE_MEM_WB];
  assign flush_IF_ID  = flush[STAGE_IF_ID];
  assign flush_ID_EX  = flush[STAGE_ID_EX];
  assign flush_EX_MEM = flush[STAGE_EX_MEM];
  assign flush_MEM_WB = flush[STAGE_MEM_WB];

`ifdef HAZARD_PERF_COUNTER_EN
  // Saturating counters; a held PC while HALTED is not a stall cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (state != ST_HALTED) && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if ((|flush) && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios
// followed by randomized stimulus, compared every cycle against a
// rule-level reference model. Counter expectations follow whether
// HAZARD_PERF_COUNTER_EN is defined for the build.
module tb_pipeline_hazard_controller;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             i_ready, d_ready;
  logic             d_readM_MEM, d_writeM_MEM, d_readM_EX;
  logic [1:0]       write_reg_addr_EX, rs_ID, rt_ID;
  logic             use_rs_ID, use_rt_ID;
  logic             isJump_ID, mispredict_EX, is_halted_WB;
  logic             pc_write;
  logic             stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic             flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit m_halted = 1'b0;
  bit m_valid  = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_ready           (i_ready),
    .d_ready           (d_ready),
    .d_readM_MEM       (d_readM_MEM),
    .d_writeM_MEM      (d_writeM_MEM),
    .d_readM_EX        (d_readM_EX),
    .write_reg_addr_EX (write_reg_addr_EX),
    .rs_ID             (rs_ID),
    .rt_ID             (rt_ID),
    .use_rs_ID         (use_rs_ID),
    .use_rt_ID         (use_rt_ID),
    .isJump_ID         (isJump_ID),
    .mispredict_EX     (mispredict_EX),
    .is_halted_WB      (is_halted_WB),
    .pc_write          (pc_write),
    .stall_IF_ID       (stall_IF_ID),
    .stall_ID_EX       (stall_ID_EX),
    .stall_EX_MEM      (stall_EX_MEM),
    .stall_MEM_WB      (stall_MEM_WB),
    .flush_IF_ID       (flush_IF_ID),
    .flush_ID_EX       (flush_ID_EX),
    .flush_EX_MEM      (flush_EX_MEM),
    .flush_MEM_WB      (flush_MEM_WB),
    .halted            (halted),
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected controls packed as
  // {pc_write, stall IF_ID..MEM_WB, flush IF_ID..MEM_WB, halted}.
  function automatic logic [9:0] expect_ctl();
    logic       pcw;
    logic [3:0] st, fl;
    logic       hl;
    bit         lu;
    pcw = 1'b1; st = 4'b0; fl = 4'b0; hl = 1'b0;
    lu = d_readM_EX && ((use_rs_ID && rs_ID == write_reg_addr_EX) ||
                        (use_rt_ID && rt_ID == write_reg_addr_EX));
    if (!reset_n) begin
      pcw = 1'b0; fl = 4'b1111;
    end else if (m_halted) begin
      pcw = 1'b0; st = 4'b1111; hl = 1'b1;
    end else if ((d_readM_MEM || d_writeM_MEM) && !d_ready) begin
      pcw = 1'b0; st = 4'b1110; fl = 4'b0001;
    end else if (mispredict_EX) begin
      fl = 4'b1100;
    end else if (lu) begin
      pcw = 1'b0; st = 4'b1000; fl = 4'b0100;
    end else begin
      if (isJump_ID) fl[3] = 1'b1;
      if (!i_ready) begin
        pcw = 1'b0; fl[3] = 1'b1;
      end
    end
    return {pcw, st, fl, hl};
  endfunction

  task automatic model_update(input logic [9:0] e);
    if (!reset_n) begin
      m_halted = 1'b0;
      m_stall  = 0;
      m_flush  = 0;
      m_valid  = 1'b1;
    end else begin
`ifdef HAZARD_PERF_COUNTER_EN
      if (!e[9] && !m_halted && m_stall < CNT_MAX) m_stall++;
      if ((|e[4:1]) && m_flush < CNT_MAX) m_flush++;
`endif
      if (is_halted_WB) m_halted = 1'b1;
    end
  endtask

  // One cycle: inputs already driven; compare mid-cycle, then advance.
  task automatic step(input string tag);
    logic [9:0] e;
    logic [9:0] got;
    #4;
    e   = expect_ctl();
    got = {pc_write, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
           flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halted};
    check({tag, "_ctl"}, 64'(got), 64'(e));
    check({tag, "_excl"},
          64'(|({stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB} &
                {flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB})), 64'd0);
    if (m_valid) begin
      check({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(m_stall));
      check({tag, "_flush_count"},  64'(flush_count),  64'(m_flush));
    end
    @(posedge clk);
    model_update(e);
    #1;
  endtask

  task automatic idle();
    i_ready = 1'b1; d_ready = 1'b1;
    d_readM_MEM = 1'b0; d_writeM_MEM = 1'b0; d_readM_EX = 1'b0;
    write_reg_addr_EX = 2'd0; rs_ID = 2'd0; rt_ID = 2'd0;
    use_rs_ID = 1'b0; use_rt_ID = 1'b0;
    isJump_ID = 1'b0; mispredict_EX = 1'b0; is_halted_WB = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step("reset");
    reset_n = 1'b1;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    step("reset0");
    step("reset1");
    reset_n = 1'b1;
    step("idle");

    // Load in EX writes $1, ID reads $1 as rs: exactly one bubble.
    d_readM_EX = 1'b1; write_reg_addr_EX = 2'd1; rs_ID = 2'd1; use_rs_ID = 1'b1;
    step("load_use");
    idle();
    step("after_load_use");

    // MEM load with d_ready low for three cycles.
    do_reset();
    d_readM_MEM = 1'b1; d_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("dmem_wait");
    d_ready = 1'b1;
    step("dmem_done");
    idle();
    step("after_dmem");

    // Mispredict beats a simultaneous load-use.
    d_readM_EX = 1'b1; write_reg_addr_EX = 2'd2; rt_ID = 2'd2; use_rt_ID = 1'b1;
    mispredict_EX = 1'b1;
    step("mispredict_load_use");
    idle();

    // Data stall hides a pending mispredict until it clears.
    d_writeM_MEM = 1'b1; d_ready = 1'b0; mispredict_EX = 1'b1;
    step("dmem_mp0");
    step("dmem_mp1");
    d_ready = 1'b1;
    step("mp_after_dmem");
    idle();

    // Jump with fetch not ready.
    i_ready = 1'b0; isJump_ID = 1'b1;
    step("jump_not_ready");
    idle();
    isJump_ID = 1'b1;
    step("jump_only");
    idle();
    i_ready = 1'b0;
    step("not_ready_only");
    idle();

    // Halt is sticky whatever the other inputs do, until reset.
    is_halted_WB = 1'b1;
    step("halt_req");
    idle();
    for (int i = 0; i < 4; i++) begin
      mispredict_EX = 1'($urandom_range(0, 1));
      d_readM_MEM   = 1'($urandom_range(0, 1));
      d_ready       = 1'($urandom_range(0, 1));
      step("halted");
    end
    idle();
    do_reset();
    step("post_halt");

    // Reset from the middle of a data-memory wait.
    d_readM_MEM = 1'b1; d_ready = 1'b0;
    step("wait_pre_reset");
    do_reset();
    idle();
    step("post_wait_reset");

    // Long data stall drives both counters to saturation when built.
    d_readM_MEM = 1'b1; d_ready = 1'b0;
    for (int i = 0; i < CNT_MAX + 5; i++) step("saturate");
    idle();
    step("after_saturate");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      reset_n           = ($urandom_range(0, 29) != 0);
      i_ready           = ($urandom_range(0, 3) != 0);
      d_ready           = ($urandom_range(0, 2) != 0);
      d_readM_MEM       = ($urandom_range(0, 2) == 0);
      d_writeM_MEM      = ($urandom_range(0, 3) == 0);
      d_readM_EX        = 1'($urandom_range(0, 1));
      write_reg_addr_EX = 2'($urandom_range(0, 3));
      rs_ID             = 2'($urandom_range(0, 3));
      rt_ID             = 2'($urandom_range(0, 3));
      use_rs_ID         = 1'($urandom_range(0, 1));
      use_rt_ID         = 1'($urandom_range(0, 1));
      isJump_ID         = ($urandom_range(0, 3) == 0);
      mispredict_EX     = ($urandom_range(0, 5) == 0);
      is_halted_WB      = ($urandom_range(0, 39) == 0);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter CNT_W, default 16, width of performance counters.
REQ-002 One clock; reset is synchronous and active-low: clk input 1, rising-edge clock.
REQ-003 reset_n  input  1  synchronous active-low reset.
REQ-004 i_ready  input  1  instruction fetch data valid this cycle.
REQ-005 d_ready  input  1  data access in MEM completes this cycle.
REQ-006 d_readM_MEM, d_writeM_MEM  input  1 each  MEM-stage access request.
REQ-007 d_readM_EX  input  1  EX-stage instruction is a load.
REQ-008 write_reg_addr_EX  input  2  load destination register.
REQ-009 rs_ID, rt_ID  input  2 each; use_rs_ID, use_rt_ID  input  1 each  source operands read in ID.
REQ-010 isJump_ID  input  1  jump resolved in ID.
REQ-011 mispredict_EX  input  1  branch outcome differs from predicted PC.
REQ-012 is_halted_WB  input  1  HLT reached WB.
REQ-013 pc_write  output  1  PC update enable.
REQ-014 stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB  output  1 each.
REQ-015 flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  output  1 each.
REQ-016 halted  output  1  core stopped; stall_cycles, flush_count  output  CNT_W each.

Function
REQ-017 FSM states RUN, DMEM_WAIT, HALTED; state register only sequential control; stage-control outputs combinational from state and inputs.
REQ-018 dmem_stall = (d_readM_MEM | d_writeM_MEM) & ~d_ready.
REQ-019 RUN->DMEM_WAIT on dmem_stall; DMEM_WAIT->RUN on d_ready; any state->HALTED on is_halted_WB; HALTED exits only by reset.
REQ-020 Priority, highest first: HALTED, dmem_stall, mispredict_EX, load-use, isJump_ID, ~i_ready.
REQ-021 HALTED: pc_write=0, all four stalls=1, all flushes=0, halted=1.
REQ-022 dmem_stall: pc_write=0, stall IF_ID/ID_EX/EX_MEM, flush_MEM_WB=1; lower-priority events suppressed this cycle.
REQ-023 mispredict_EX: pc_write=1, flush_IF_ID=1, flush_ID_EX=1; load-use and jump ignored.
REQ-024 load-use = d_readM_EX & ((use_rs_ID & rs_ID==write_reg_addr_EX) | (use_rt_ID & rt_ID==write_reg_addr_EX)): pc_write=0, stall_IF_ID=1, flush_ID_EX=1; exactly one bubble.
REQ-025 isJump_ID alone: pc_write=1, flush_IF_ID=1.
REQ-026 ~i_ready alone: pc_write=0, flush_IF_ID=1; combined with jump, jump response plus pc_write=0.
REQ-027 No event: pc_write=1, all stalls and flushes 0.
REQ-028 A stall and flush never asserted together on the same register.

Reset
REQ-029 reset_n=0 at clk edge: state=RUN, counters=0; while reset asserted outputs read pc_write=0, all flushes=1, stalls=0, halted=0.
REQ-030 Reset mid-DMEM_WAIT or HALTED returns to RUN next cycle with no residual stall.

Configuration
REQ-031 Macro HAZARD_PERF_COUNTER_EN defined: stall_cycles increments each cycle pc_write=0 outside HALTED/reset; flush_count increments each cycle any flush asserted outside reset; both saturate at 2^CNT_W-1.
REQ-032 Macro undefined: no counter flops; stall_cycles and flush_count tied to 0.

Structure
REQ-033 FSM state encoding and stage-index constants live in the shared constants package beside WORD_SIZE and opcodes.
REQ-034 Load-use comparator is one natural sub-module: load_use_detector, purely combinational.

Verification
REQ-035 Load at EX writing $1, ID reads rs=$1 -> one cycle pc_write=0, stall_IF_ID=1, flush_ID_EX=1, then normal.
REQ-036 MEM load, d_ready low 3 cycles -> DMEM_WAIT 3 cycles, flush_MEM_WB=1 each, stall_cycles=3 (EN defined).
REQ-037 mispredict_EX with load-use same cycle -> flush_IF_ID=flush_ID_EX=1, pc_write=1, stall_IF_ID=0.
REQ-038 dmem_stall with mispredict_EX held 2 cycles, then d_ready -> flushes only in cycle after stall ends.
REQ-039 is_halted_WB=1 -> halted=1 next cycle, all stalls=1 indefinitely; reset_n=0 one cycle -> RUN, counters 0.
REQ-040 i_ready=0 with isJump_ID=1 -> flush_IF_ID=1, pc_write=0; macro undefined -> counters read 0 throughout.
